// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file geometry, address/data types and requester indices.
package rf_pkg;
    localparam int RF_PW = 3;
    localparam int RF_DW = 8;
    localparam int RF_N = 2 ** RF_PW;
    typedef logic [RF_PW-1:0] rf_addr_t;
    typedef logic [RF_DW-1:0] rf_data_t;
    typedef enum logic {REQ_ALU = 1'b0, REQ_LD = 1'b1} req_idx_t;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: busy bit per register, set on reserve, cleared on commit, with double-reserve flag.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int pw = RF_PW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rsv_en,
    input  logic [pw-1:0]   rsv_addr,
    input  logic            clr_en,
    input  logic [pw-1:0]   clr_addr,
    input  logic [pw-1:0]   chk_addr_a,
    input  logic [pw-1:0]   chk_addr_b,
    output logic            haz_a,
    output logic            haz_b,
    output logic [2**pw-1:0] busy,
    output logic            dbl_rsv
);
    localparam int n = 2 ** pw;
    localparam logic [n-1:0] one = 1;

    logic [n-1:0] set_mask;
    logic [n-1:0] clr_mask;
    logic         dbl_hit;

    // OR-ing the set mask after the clear makes a same-register set win over the commit.
    always_comb begin
        set_mask = rsv_en ? one << rsv_addr : '0;
        clr_mask = clr_en ? one << clr_addr : '0;
        dbl_hit  = rsv_en && busy[rsv_addr] && !(clr_en && clr_addr == rsv_addr);
        haz_a    = busy[chk_addr_a];
        haz_b    = busy[chk_addr_b];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy    <= '0;
            dbl_rsv <= 1'b0;
        end else begin
            busy    <= (busy & ~clr_mask) | set_mask;
            dbl_rsv <= dbl_rsv | dbl_hit;
        end
    end
endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin sharing of the register-file write port between ALU and load write-back.
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int pw = RF_PW,
    parameter int dw = RF_DW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    input  logic [pw-1:0]    req_addr0,
    input  logic [pw-1:0]    req_addr1,
    input  logic [dw-1:0]    req_dat0,
    input  logic [dw-1:0]    req_dat1,
    output logic [1:0]       req_ready,
    input  logic             rsv_en,
    input  logic [pw-1:0]    rsv_addr,
    input  logic [pw-1:0]    chk_addrA,
    input  logic [pw-1:0]    chk_addrB,
    output logic             hazA,
    output logic             hazB,
    output logic             rf_wr_en,
    output logic [pw-1:0]    rf_wr_addr,
    output logic [dw-1:0]    rf_dat_in,
    output logic [2**pw-1:0] busy,
    output logic             dbl_rsv
);
    req_idx_t rr;
    logic [1:0] grant;
    logic xfer;

    always_comb begin
        grant[0]  = req_valid[0] && (!req_valid[1] || rr == REQ_ALU);
        grant[1]  = req_valid[1] && (!req_valid[0] || rr == REQ_LD);
        req_ready = reset ? 2'b00 : grant;
        xfer      = |req_ready;
    end

    // After a transfer the pointer moves to the requester that lost, so a waiter is next.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr         <= REQ_ALU;
            rf_wr_en   <= 1'b0;
            rf_wr_addr <= '0;
            rf_dat_in  <= '0;
        end else begin
            rf_wr_en <= xfer;
            if (xfer) begin
                rr         <= req_ready[0] ? REQ_LD : REQ_ALU;
                rf_wr_addr <= req_ready[0] ? req_addr0 : req_addr1;
                rf_dat_in  <= req_ready[0] ? req_dat0 : req_dat1;
            end
        end
    end

    rf_scoreboard #(.pw(pw)) u_sb (
        .clk        (clk),
        .reset      (reset),
        .rsv_en     (rsv_en),
        .rsv_addr   (rsv_addr),
        .clr_en     (rf_wr_en),
        .clr_addr   (rf_wr_addr),
        .chk_addr_a (chk_addrA),
        .chk_addr_b (chk_addrB),
        .haz_a      (hazA),
        .haz_b      (hazB),
        .busy       (busy),
        .dbl_rsv    (dbl_rsv)
    );
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed and randomized checks of rf_write_arbiter against a transaction-level model.
module tb_rf_write_arbiter;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] req_valid = '0;
    logic [2:0] req_addr0 = '0, req_addr1 = '0;
    logic [7:0] req_dat0 = '0, req_dat1 = '0;
    logic [1:0] req_ready;
    logic       rsv_en = 1'b0;
    logic [2:0] rsv_addr = '0, chk_addrA = '0, chk_addrB = '0;
    logic       hazA, hazB, rf_wr_en, dbl_rsv;
    logic [2:0] rf_wr_addr;
    logic [7:0] rf_dat_in, busy;

    rf_write_arbiter dut (
        .clk(clk), .reset(reset), .req_valid(req_valid),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_dat0(req_dat0), .req_dat1(req_dat1), .req_ready(req_ready),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .chk_addrA(chk_addrA), .chk_addrB(chk_addrB), .hazA(hazA), .hazB(hazB),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_dat_in(rf_dat_in),
        .busy(busy), .dbl_rsv(dbl_rsv)
    );

    always #5 clk = ~clk;

    int passed = 0, total = 0;
    // model: pending reservations as a per-register flag, plus the write waiting to commit
    bit m_busy[8];
    bit m_dbl, m_wen;
    int m_rr, m_waddr, m_wdat, last_g;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int mgrant();
        if (reset) return -1;
        if (req_valid == 2'b11) return m_rr;
        if (req_valid[0]) return 0;
        if (req_valid[1]) return 1;
        return -1;
    endfunction

    function automatic logic [7:0] mbusy_vec();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic settle();
        int g;
        #1;
        g = mgrant();
        chk("ready", req_ready, g < 0 ? 0 : (1 << g));
        chk("hazA", hazA, m_busy[chk_addrA]);
        chk("hazB", hazB, m_busy[chk_addrB]);
    endtask

    task automatic clk_edge();
        int g;
        bit nb[8];
        @(posedge clk);
        g = mgrant();
        nb = m_busy;
        if (m_wen) nb[m_waddr] = 0;
        if (rsv_en) begin
            if (m_busy[rsv_addr] && !(m_wen && m_waddr == int'(rsv_addr))) m_dbl = 1;
            nb[rsv_addr] = 1;
        end
        m_busy = nb;
        m_wen = (g >= 0);
        if (g >= 0) begin
            m_waddr = g == 1 ? int'(req_addr1) : int'(req_addr0);
            m_wdat  = g == 1 ? int'(req_dat1) : int'(req_dat0);
            m_rr    = 1 - g;
        end
        last_g = g;
        #1;
        chk("wr_en", rf_wr_en, m_wen);
        chk("wr_addr", rf_wr_addr, m_waddr);
        chk("dat_in", rf_dat_in, m_wdat);
        chk("busy", busy, mbusy_vec());
        chk("dbl_rsv", dbl_rsv, m_dbl);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = 2'b11;
        rsv_en = 1'b0;
        #1;
        chk("rst_wr_en", rf_wr_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dbl", dbl_rsv, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_addr", rf_wr_addr, 0);
        chk("rst_dat", rf_dat_in, 0);
        for (int i = 0; i < 8; i++) m_busy[i] = 0;
        m_dbl = 0; m_wen = 0; m_rr = 0; m_waddr = 0; m_wdat = 0;
        #1;
        req_valid = 2'b00;
        reset = 1'b0;
    endtask

    initial begin
        int eg[4] = '{1, 2, 1, 2};
        int ea[4] = '{1, 6, 1, 6};
        bit pend[2];
        logic [2:0] pa[2];
        logic [7:0] pd[2];
        do_reset();
        // single requester
        req_valid = 2'b01; req_addr0 = 3; req_dat0 = 8'hA5;
        settle();
        chk("t2_ready", req_ready, 2'b01);
        clk_edge();
        chk("t2_en", rf_wr_en, 1);
        chk("t2_addr", rf_wr_addr, 3);
        chk("t2_dat", rf_dat_in, 8'hA5);
        req_valid = 2'b00;
        settle();
        clk_edge();
        chk("t2_idle", rf_wr_en, 0);
        // contention from a fresh reset
        do_reset();
        req_valid = 2'b11; req_addr0 = 1; req_addr1 = 6; req_dat0 = 8'h11; req_dat1 = 8'h66;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("t3_grant", req_ready, eg[i]);
            clk_edge();
            chk("t3_addr", rf_wr_addr, ea[i]);
        end
        req_valid = 2'b00;
        // hazard lifecycle on r5
        rsv_en = 1'b1; rsv_addr = 5;
        settle();
        clk_edge();
        rsv_en = 1'b0; chk_addrA = 5;
        settle();
        chk("t4_haz_set", hazA, 1);
        clk_edge();
        req_valid = 2'b01; req_addr0 = 5; req_dat0 = 8'h55;
        settle();
        clk_edge();
        req_valid = 2'b00;
        settle();
        chk("t4_haz_wr", hazA, 1);
        chk("t4_wr_en", rf_wr_en, 1);
        clk_edge();
        settle();
        chk("t4_haz_clr", hazA, 0);
        chk("t4_busy5", busy[5], 0);
        // same-edge set and clear of r2
        rsv_en = 1'b1; rsv_addr = 2;
        settle();
        clk_edge();
        rsv_en = 1'b0; req_valid = 2'b10; req_addr1 = 2; req_dat1 = 8'h22;
        settle();
        clk_edge();
        req_valid = 2'b00; rsv_en = 1'b1; rsv_addr = 2;
        settle();
        clk_edge();
        rsv_en = 1'b0;
        chk("t5_busy2", busy[2], 1);
        chk("t5_dbl", dbl_rsv, 0);
        // double reserve of r7
        rsv_en = 1'b1; rsv_addr = 7;
        settle();
        clk_edge();
        settle();
        clk_edge();
        rsv_en = 1'b0;
        chk("t6_busy7", busy[7], 1);
        chk("t6_dbl", dbl_rsv, 1);
        for (int i = 0; i < 3; i++) begin
            settle();
            clk_edge();
        end
        chk("t6_sticky", dbl_rsv, 1);
        // asynchronous reset with a write in flight
        req_valid = 2'b01; req_addr0 = 4; req_dat0 = 8'h44;
        settle();
        clk_edge();
        req_valid = 2'b00;
        chk("t1_inflight", rf_wr_en, 1);
        do_reset();
        // randomized traffic honouring the hold-while-waiting rule
        pend = '{0, 0};
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++)
                if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    pend[i] = 1;
                    pa[i] = 3'($urandom);
                    pd[i] = 8'($urandom);
                end
            req_valid = {pend[1], pend[0]};
            req_addr0 = pa[0]; req_dat0 = pd[0];
            req_addr1 = pa[1]; req_dat1 = pd[1];
            rsv_en = ($urandom_range(0, 3) == 0);
            rsv_addr = 3'($urandom);
            chk_addrA = 3'($urandom);
            chk_addrB = 3'($urandom);
            settle();
            clk_edge();
            if (last_g >= 0) pend[last_g] = 0;
            if (c % 97 == 50) begin
                do_reset();
                pend = '{0, 0};
            end
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout passed=%0d total=%0d", passed, total);
        $fatal(1, "timeout");
    end
endmodule
